bcd_convert_scheduler: RTL
==========================

// Module: bcd_convert_scheduler
// PURPOSE
//  Time-shares one combinational bin_2_bcd converter between NUM_CH requesters.
//  Typical requesters are operand A, operand B and the result of the arithmetic unit.
//  Each request is granted round-robin and its binary value is presented to the converter.
//  The BCD digits are captured into a per-channel display register that feeds the 7-segment decoders.
//  Values above 999 are flagged as overflow rather than shown as invalid BCD.
// PARAMETERS
//  NUM_CH    3   number of requesters/display channels (2..8)
//  CONV_LAT  1   cycles conv_bin is held stable before converter outputs are sampled (>=1)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NUM_CH     per-channel request; held high until accepted
//  req_bin    in   NUM_CH*12  per-channel binary value; ch i = [12*i+11:12*i]
//  req_ready  out  NUM_CH     one-hot accept pulse; value sampled this cycle
//  conv_bin   out  12         registered input to the shared bin_2_bcd instance
//  conv_huns  in   4          converter hundreds digit
//  conv_tens  in   4          converter tens digit
//  conv_ones  in   4          converter ones digit
//  disp_bcd   out  NUM_CH*12  per-channel {huns,tens,ones}; ch i = [12*i+11:12*i]
//  disp_ovf   out  NUM_CH     per-channel overflow flag (last captured value > 999)
//  done       out  NUM_CH     one-cycle pulse: the channel's disp_bcd/disp_ovf were just updated
//  busy       out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=0; all outputs 0 (conv_bin, disp_bcd, disp_ovf, done, req_ready, busy).
//  FSM states: IDLE -> WAIT -> CAPT -> IDLE.
//  IDLE:
//   - Grant the first channel with req_valid set, searching from rr_ptr upward with wrap.
//   - req_ready is combinational in IDLE only; at most one bit is set.
//   - On grant: conv_bin<=req_bin[g]; chan<=g; ovf_r<=(req_bin[g]>999); cnt<=0; go to WAIT.
//   - rr_ptr<=(g+1) mod NUM_CH.
//   - With no req_valid set: stay in IDLE; conv_bin holds its value.
//  WAIT: cnt increments each cycle; when cnt==CONV_LAT-1, go to CAPT.
//  CAPT:
//   - disp_bcd[chan]<={conv_huns,conv_tens,conv_ones}, or 12'hFFF if ovf_r.
//   - disp_ovf[chan]<=ovf_r; done[chan]<=1 (registered, single cycle); go to IDLE.
//  Latency: grant at cycle T -> disp_bcd/done visible at T+CONV_LAT+2.
//  Next grant is possible in the done cycle; throughput is 1 conversion per CONV_LAT+2 cycles.
//  Other channels' disp_bcd/disp_ovf are never disturbed by a conversion.
//  Requester deasserting req_valid before req_ready: legal; the request is dropped and no grant is issued.
//  Same channel re-requesting immediately: it yields to any other pending channel (rr_ptr has moved past it).
//  Boundaries:
//   - bin=999 is valid (digits 9,9,9, ovf=0).
//   - bin=1000..4095 -> digits F,F,F, ovf=1.
//   - A later valid value clears ovf.
//  Reset mid-conversion: the conversion is aborted, no done pulse, all displays are cleared.
// TESTING
//  1 Reset, ch1 requests 12'h1C8 (456) -> req_ready=3'b010 at T.
//    With CONV_LAT=1, disp_bcd ch1=12'h456 and done=3'b010 at T+3; ch0/ch2 stay 0.
//  2 All 3 channels request 7, 250, 999 simultaneously from reset.
//    Grants in order ch0,ch1,ch2, spaced 3 cycles apart.
//    Final displays 12'h007, 12'h250, 12'h999; ovf=0.
//  3 ch2 requests 1000, then 4095 -> ovf[2]=1, disp 12'hFFF each time.
//    Then ch2 requests 0 -> ovf[2]=0, disp 12'h000.
//  4 ch0 holds req_valid continuously while ch1 requests once.
//    ch1 is granted immediately after ch0's first conversion (round-robin fairness; no starvation).
//  5 Assert rst during WAIT of a ch1 conversion.
//    Result: no done pulse, all disp_bcd=0, busy=0; the next request is serviced normally.
//  6 CONV_LAT=3: a 12-bit value sweep over 0..999 matches the golden huns*100+tens*10+ones.
//    Each done pulse lands exactly 5 cycles after its grant.

Source files
------------

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler that time-shares one combinational bin_2_bcd converter
// between NUM_CH requesters and captures the BCD digits into per-channel display registers.
module bcd_convert_scheduler #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CONV_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*12-1:0] req_bin,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [11:0]          conv_bin,
    input  logic [3:0]           conv_huns,
    input  logic [3:0]           conv_tens,
    input  logic [3:0]           conv_ones,
    output logic [NUM_CH*12-1:0] disp_bcd,
    output logic [NUM_CH-1:0]    disp_ovf,
    output logic [NUM_CH-1:0]    done,
    output logic                 busy
);

    localparam int unsigned BIN_W = 12;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
    localparam int unsigned SUM_W = CH_W + 1;
    localparam logic [BIN_W-1:0] MAX_DEC = BIN_W'(999);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } state_e;

    state_e                  state_q,    state_d;
    logic [CH_W-1:0]         rr_ptr_q,   rr_ptr_d;
    logic [CH_W-1:0]         chan_q,     chan_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic                    ovf_r_q,    ovf_r_d;
    logic                    busy_q,     busy_d;
    logic [BIN_W-1:0]        conv_bin_q, conv_bin_d;
    logic [NUM_CH*BIN_W-1:0] disp_bcd_q, disp_bcd_d;
    logic [NUM_CH-1:0]       disp_ovf_q, disp_ovf_d;
    logic [NUM_CH-1:0]       done_q,     done_d;

    logic                    grant_vld_c;
    logic [CH_W-1:0]         grant_idx_c;
    logic [BIN_W-1:0]        grant_bin_c;
    logic [SUM_W-1:0]        idx_sum_c;

    // First requester at or after rr_ptr, wrapping modulo NUM_CH
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        idx_sum_c   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx_sum_c = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (idx_sum_c >= SUM_W'(NUM_CH)) begin
                idx_sum_c = idx_sum_c - SUM_W'(NUM_CH);
            end
            if (!grant_vld_c && req_valid[idx_sum_c[CH_W-1:0]]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = idx_sum_c[CH_W-1:0];
            end
        end
        grant_bin_c = req_bin[32'(grant_idx_c)*BIN_W +: BIN_W];
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_vld_c) begin
            req_ready[grant_idx_c] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        ovf_r_d    = ovf_r_q;
        conv_bin_d = conv_bin_q;
        disp_bcd_d = disp_bcd_q;
        disp_ovf_d = disp_ovf_q;
        done_d     = '0;

        case (state_q)
            IDLE: begin
                if (grant_vld_c) begin
                    conv_bin_d = grant_bin_c;
                    chan_d     = grant_idx_c;
                    ovf_r_d    = (grant_bin_c > MAX_DEC);
                    cnt_d      = '0;
                    rr_ptr_d   = (grant_idx_c == CH_W'(NUM_CH - 1)) ? '0
                                                                    : grant_idx_c + CH_W'(1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CONV_LAT - 1)) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                // Out-of-range values show all-F instead of invalid BCD digits
                disp_bcd_d[32'(chan_q)*BIN_W +: BIN_W] = ovf_r_q ? {BIN_W{1'b1}}
                                                                 : {conv_huns, conv_tens, conv_ones};
                disp_ovf_d[chan_q] = ovf_r_q;
                done_d[chan_q]     = 1'b1;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            chan_q     <= '0;
            cnt_q      <= '0;
            ovf_r_q    <= 1'b0;
            busy_q     <= 1'b0;
            conv_bin_q <= '0;
            disp_bcd_q <= '0;
            disp_ovf_q <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            chan_q     <= chan_d;
            cnt_q      <= cnt_d;
            ovf_r_q    <= ovf_r_d;
            busy_q     <= busy_d;
            conv_bin_q <= conv_bin_d;
            disp_bcd_q <= disp_bcd_d;
            disp_ovf_q <= disp_ovf_d;
            done_q     <= done_d;
        end
    end

    assign conv_bin = conv_bin_q;
    assign disp_bcd = disp_bcd_q;
    assign disp_ovf = disp_ovf_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
